// File: rtl/ws2812b_pkg.sv
// Shared constants and types for the WS2812B LED path: serializer timing
// defaults, serializer state encoding, and the byte assembler's pixel layout.
package ws2812b_pkg;

    // Default timing at a 64 MHz clock.
    localparam int unsigned DEF_T0H_CYCLES   = 26;
    localparam int unsigned DEF_T1H_CYCLES   = 51;
    localparam int unsigned DEF_BIT_CYCLES   = 80;
    localparam int unsigned DEF_RESET_CYCLES = 3200;

    // Byte assembler layout: one pixel is three bytes sent G, R, B.
    localparam int unsigned BYTES_PER_PIXEL = 3;
    localparam int unsigned GRB_IDX_GREEN   = 0;
    localparam int unsigned GRB_IDX_RED     = 1;
    localparam int unsigned GRB_IDX_BLUE    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BIT   = 2'd1,
        ST_LATCH = 2'd2
    } ws_state_e;

    function automatic int unsigned high_cycles(input logic bit_val,
                                                input int unsigned t0h,
                                                input int unsigned t1h);
        return bit_val ? t1h : t0h;
    endfunction

endpackage

// File: rtl/ws2812b_byte_serializer.sv
// Serializes GRB bytes MSB-first onto a WS2812B data line, with an optional
// low latch gap after a byte. The bit timer is kept inline.
module ws2812b_byte_serializer
    import ws2812b_pkg::*;
#(
    parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    input  logic       latch_req,
    output logic       busy,
    output logic       led_out
);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES))
    begin : g_bad_bit_timing
        $error("ws2812b_byte_serializer: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset_timing
        $error("ws2812b_byte_serializer: need RESET_CYCLES >= 1");
    end

    localparam int unsigned BIT_CNT_W = $clog2(BIT_CYCLES + 1);
    localparam int unsigned GAP_CNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BIT_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(RESET_CYCLES - 1);

    ws_state_e              state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   latch_pend_q, latch_pend_d;
    logic                   led_q, led_d;
    logic                   ready_c;
    logic                   accept;
    logic                   bit_last;
    logic                   frame_last;
    logic [BIT_CNT_W-1:0]   high_d;

    // Handshake: a byte transfers on a rising clk edge where byte_valid and
    // byte_ready are both high; byte_ready never depends on byte_valid, and
    // upstream must hold byte_data stable while byte_valid is high.
    assign byte_ready = rst_n & ready_c;
    assign accept     = byte_valid & ready_c;

    assign bit_last   = (bit_cnt_q == BIT_LAST);
    assign frame_last = bit_last && (bit_idx_q == 3'd0);

    assign busy    = (state_q != ST_IDLE) || latch_pend_q;
    assign led_out = led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= 8'd0;
            bit_idx_q    <= 3'd0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            latch_pend_q <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            latch_pend_q <= latch_pend_d;
            led_q        <= led_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        latch_pend_d = latch_pend_q;
        ready_c      = 1'b0;

        if (latch_req && (state_q != ST_LATCH)) begin
            latch_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (byte_valid) begin
                    state_d   = ST_BIT;
                    shift_d   = byte_data;
                    bit_idx_d = 3'd7;
                    bit_cnt_d = '0;
                end else if (latch_pend_q) begin
                    state_d   = ST_LATCH;
                    gap_cnt_d = '0;
                end
            end

            ST_BIT: begin
                // A pending latch closes the ready window so the gap wins.
                ready_c = frame_last && !latch_pend_q;
                if (!bit_last) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (bit_idx_q != 3'd0) begin
                    bit_idx_d = bit_idx_q - 3'd1;
                    bit_cnt_d = '0;
                    shift_d   = {shift_q[6:0], 1'b0};
                end else if (latch_pend_q) begin
                    state_d   = ST_LATCH;
                    gap_cnt_d = '0;
                end else if (accept) begin
                    shift_d   = byte_data;
                    bit_idx_d = 3'd7;
                    bit_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LATCH: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d      = ST_IDLE;
                    gap_cnt_d    = '0;
                    latch_pend_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // led_out is registered from the next-cycle view so the line never glitches.
    always_comb begin
        high_d = BIT_CNT_W'(high_cycles(shift_d[7], T0H_CYCLES, T1H_CYCLES));
        led_d  = (state_d == ST_BIT) && (bit_cnt_d < high_d);
    end

endmodule

// File: doc/ws2812b_byte_serializer.md
WS2812B_BYTE_SERIALIZER -- requirements
Module: ws2812b_byte_serializer

Interface
REQ-001 SHALL have parameter T0H_CYCLES, default 26, meaning high-time clocks for a 0 bit (0.4 us at 64 MHz).
REQ-002 SHALL have parameter T1H_CYCLES, default 51, meaning high-time clocks for a 1 bit (0.8 us).
REQ-003 SHALL have parameter BIT_CYCLES, default 80, meaning total clocks per bit (1.25 us).
REQ-004 SHALL have parameter RESET_CYCLES, default 3200, meaning low-time clocks of the latch/reset gap (50 us).
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port byte_valid  input  1  upstream offers byte_data.
REQ-008 SHALL have port byte_data  input  8  GRB colour byte, transmitted MSB first.
REQ-009 SHALL have port byte_ready  output  1  block accepts byte_data this cycle.
REQ-010 SHALL have port latch_req  input  1  single-cycle pulse requesting a reset gap after the current byte.
REQ-011 SHALL have port busy  output  1  high while a byte, a pending latch, or a gap is in progress.
REQ-012 SHALL have port led_out  output  1  WS2812B data line.

Function
REQ-013 SHALL use the states IDLE, BIT and LATCH.
REQ-014 SHALL accept a byte on a rising edge where byte_valid and byte_ready are both high; no other edge accepts a byte.
REQ-015 SHALL hold byte_ready high in IDLE.
REQ-016 SHALL hold byte_ready high on the last cycle of bit 0 in BIT when no latch is pending; otherwise byte_ready SHALL be low in BIT and LATCH.
REQ-017 SHALL, on acceptance, load a shift register and set bit index 7 with cycle counter 0, then enter BIT.
REQ-018 SHALL drive led_out high starting the cycle after acceptance.
REQ-019 SHALL, for each bit, drive led_out high for exactly T1H_CYCLES (bit=1) or T0H_CYCLES (bit=0), then low for the remainder of BIT_CYCLES.
REQ-020 SHALL make a byte occupy exactly 8*BIT_CYCLES cycles.
REQ-021 SHALL, on back-to-back acceptance at the REQ-016 cycle, start the next byte with no idle cycle between frames.
REQ-022 SHALL set a latch-pending flag when latch_req is high in any state other than LATCH.
REQ-023 SHALL, when latch_req coincides with acceptance in IDLE, accept the byte and send the gap after it.
REQ-024 SHALL, in IDLE with latch pending and no acceptance, enter LATCH on the next edge.
REQ-025 SHALL, at the end of a byte with latch pending, enter LATCH; the latch takes priority over a new byte.
REQ-026 SHALL, in LATCH, hold led_out low for exactly RESET_CYCLES cycles, clear the pending flag, then return to IDLE.
REQ-027 SHALL ignore latch_req received during LATCH.
REQ-028 SHALL drive busy = (state != IDLE) or latch pending.
REQ-029 SHALL drive led_out directly from a flip-flop (glitch-free).
REQ-030 SHALL size counters to hold RESET_CYCLES-1 and BIT_CYCLES-1 without wrap.
REQ-031 SHALL require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and RESET_CYCLES >= 1; violation SHALL be a elaboration-time error.

Reset
REQ-032 SHALL, while rst_n is low, immediately force state=IDLE, led_out=0, busy=0, latch pending=0 and counters=0, independent of clk.
REQ-033 SHALL hold byte_ready low during reset and drive it high in the first cycle after rst_n deasserts.
REQ-034 SHALL discard a byte interrupted by reset, with no resumption.

Structure
REQ-035 SHALL place default timing constants and the state encoding in shared package ws2812b_pkg, alongside the byte assembler's constants.
REQ-036 SHALL be implemented as one module with no sub-module; the bit timer is inline.

Verification (T0H=2, T1H=5, BIT=8, RESET=20)
REQ-037 SHALL test reset: rst_n low for 3 cycles -> led_out=0, busy=0 asynchronously; byte_ready=1 the cycle after release.
REQ-038 SHALL test a single byte: 0xA5 -> high widths 5,2,5,2,2,5,2,5 in consecutive 8-cycle windows, 64 cycles total, byte_ready high only in the final cycle.
REQ-039 SHALL test back-to-back bytes: 0xFF then 0x00 with byte_valid held -> 128 contiguous cycles (8x5-high then 8x2-high), no gap.
REQ-040 SHALL test a latch with a byte: 0x80 plus latch_req in the same cycle -> 5-high frame, then 7x2-high, then 20 low cycles; byte_ready=0 throughout; then IDLE with busy=0.
REQ-041 SHALL test a latch in IDLE: latch_req then byte_valid held -> byte accepted only after 20 gap cycles.
REQ-042 SHALL test reset mid-byte: rst_n low at cycle 20 of 0xFF -> led_out=0 immediately; after release, 0x01 transmits cleanly.
